lif_neuron_dual_core: RTL

- Dual-input leaky integrate-and-fire neuron core. Sits directly downstream of the serial parameter loader.
- Consumes the loader's weight_a, weight_b, leak_rate, threshold, leak_cycles and params_ready.
- Integrates two binary spike channels into an 8-bit membrane, applies periodic leak, fires on threshold crossing, then enforces a refractory period.

---
 rtl/lif_neuron_dual_core.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lif_neuron_dual_core.sv
`default_nettype none
// ============================================================================
// Module   : lif_neuron_dual_core
// Brief    : Dual-input leaky integrate-and-fire neuron. Two binary spike
//            channels are weighted into an 8-bit saturating membrane, a
//            periodic leak is applied, a spike fires on threshold crossing
//            and a refractory period follows.
// Revision : 1.0 - initial release
// ============================================================================
module lif_neuron_dual_core #(
  parameter int         REFRACTORY_CYCLES = 4,
  parameter logic [7:0] RESET_POTENTIAL   = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       chan_a,
  input  logic       chan_b,
  input  logic [2:0] weight_a,
  input  logic [2:0] weight_b,
  input  logic [7:0] leak_rate,
  input  logic [7:0] threshold,
  input  logic [3:0] leak_cycles,
  input  logic       params_ready,
  output logic       spike_out,
  output logic [7:0] membrane_potential,
  output logic [7:0] spike_count,
  output logic [1:0] neuron_state
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ACCUMULATE = 2'd1,
    ST_REFRACTORY = 2'd2
  } state_t;

  // Refractory counter is 8 bits wide; REFRACTORY_CYCLES must fit in 0..255.
  localparam logic [7:0] C_REF_LOAD = 8'(REFRACTORY_CYCLES);

  state_t      state_q,    state_d;
  logic [7:0]  membrane_q, membrane_d;
  logic [7:0]  count_q,    count_d;
  logic [3:0]  leak_cnt_q, leak_cnt_d;
  logic [7:0]  ref_cnt_q,  ref_cnt_d;
  logic        spike_q,    spike_d;

  logic [9:0]  sum_ext;
  logic [7:0]  sum_sat;
  logic [7:0]  sum_final;
  logic        leak_event;

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      membrane_q <= 8'd0;
      count_q    <= 8'd0;
      leak_cnt_q <= 4'd0;
      ref_cnt_q  <= 8'd0;
      spike_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      membrane_q <= membrane_d;
      count_q    <= count_d;
      leak_cnt_q <= leak_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      spike_q    <= spike_d;
    end
  end

  // Integrate/leak/fire datapath and next-state decision.
  always_comb begin
    state_d    = state_q;
    membrane_d = membrane_q;
    count_d    = count_q;
    leak_cnt_d = leak_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    spike_d    = 1'b0;

    // Weighted sum held at 10 bits so saturation can be detected.
    sum_ext = {2'b00, membrane_q}
            + {7'd0, (chan_a ? weight_a : 3'd0)}
            + {7'd0, (chan_b ? weight_b : 3'd0)};
    sum_sat = (sum_ext > 10'd255) ? 8'd255 : sum_ext[7:0];

    // The >= lets a shrinking leak period still trigger instead of wrapping.
    leak_event = (leak_cycles != 4'd0) && (leak_cnt_q >= (leak_cycles - 4'd1));
    if (leak_event) begin
      sum_final = (sum_sat >= leak_rate) ? (sum_sat - leak_rate) : 8'd0;
    end else begin
      sum_final = sum_sat;
    end

    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          leak_cnt_d = 4'd0;
          if (params_ready) begin
            state_d = ST_ACCUMULATE;
          end
        end

        ST_ACCUMULATE: begin
          if (!params_ready) begin
            // Losing parameters overrides any integration on this edge.
            state_d    = ST_IDLE;
            leak_cnt_d = 4'd0;
            ref_cnt_d  = 8'd0;
          end else begin
            if (leak_event) begin
              leak_cnt_d = 4'd0;
            end else if (leak_cycles != 4'd0) begin
              leak_cnt_d = leak_cnt_q + 4'd1;
            end else begin
              leak_cnt_d = 4'd0;
            end

            if (sum_final >= threshold) begin
              spike_d    = 1'b1;
              membrane_d = RESET_POTENTIAL;
              count_d    = count_q + 8'd1;
              leak_cnt_d = 4'd0;
              if (REFRACTORY_CYCLES != 0) begin
                state_d   = ST_REFRACTORY;
                ref_cnt_d = C_REF_LOAD;
              end
            end else begin
              membrane_d = sum_final;
            end
          end
        end

        ST_REFRACTORY: begin
          if (!params_ready) begin
            state_d    = ST_IDLE;
            leak_cnt_d = 4'd0;
            ref_cnt_d  = 8'd0;
          end else begin
            membrane_d = RESET_POTENTIAL;
            leak_cnt_d = 4'd0;
            if (ref_cnt_q <= 8'd1) begin
              state_d   = ST_ACCUMULATE;
              ref_cnt_d = 8'd0;
            end else begin
              ref_cnt_d = ref_cnt_q - 8'd1;
            end
          end
        end

        default: begin
          state_d    = ST_IDLE;
          leak_cnt_d = 4'd0;
          ref_cnt_d  = 8'd0;
        end
      endcase
    end
  end

  assign spike_out          = spike_q;
  assign membrane_potential = membrane_q;
  assign spike_count        = count_q;
  assign neuron_state       = state_q;

endmodule
`default_nettype wire
